// File: rtl/control_rotador.sv
// ---------------------------------------------------------------------------
// control_rotador
//   Frame sequencer in front of the word rotator. Each cycle it samples one
//   BUS_SIZE frame, checks the head word (must be all ones) and the tail word
//   (must equal the running sequence number), and drives the rotator controls
//   aligned with the registered copy of the frame.
//
// Ports
//   clk          in   1         clock, posedge
//   reset        in   1         asynchronous, active-low reset
//   data_in      in   BUS_SIZE  incoming frame, one per cycle
//   data_q       out  BUS_SIZE  data_in registered, aligned with the controls
//   rot_en       out  1         data_q is an accepted frame
//   rot_sel      out  SEL_W     rotate amount = tail % WORD_NUM (0 if rot_en=0)
//   control_out  out  WORD_NUM  one-hot of rot_sel when rot_en=1, else 0
//   error_out    out  1         high while in ERROR
//   state_out    out  2         current state encoding
//
// States
//   RESET  (00) | first cycle after reset release, frame ignored
//   WAIT   (01) | waiting for a start frame (head all ones, tail 0)
//   ACTIVE (10) | in sequence, tail must match the expected number
//   ERROR  (11) | too many consecutive bad frames, waiting for a start frame
// ---------------------------------------------------------------------------
module control_rotador #(
  parameter int BUS_SIZE   = 60,
  parameter int WORD_SIZE  = 6,
  parameter int WORD_NUM   = 10,
  parameter int SEL_W      = 4,
  parameter int ERR_THRESH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_SIZE-1:0] data_in,
  output logic [BUS_SIZE-1:0] data_q,
  output logic                rot_en,
  output logic [SEL_W-1:0]    rot_sel,
  output logic [WORD_NUM-1:0] control_out,
  output logic                error_out,
  output logic [1:0]          state_out
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_ERROR  = 2'b11
  } state_e;

  localparam logic [3:0] THRESH = 4'(ERR_THRESH);

  // Registered state and outputs
  state_e                state_q,    state_d;
  logic [WORD_SIZE-1:0]  expected_q, expected_d;
  logic [3:0]            miss_q,     miss_d;
  logic [BUS_SIZE-1:0]   frame_q;
  logic                  rot_en_q,   rot_en_d;
  logic [SEL_W-1:0]      rot_sel_q,  rot_sel_d;
  logic [WORD_NUM-1:0]   ctrl_q,     ctrl_d;
  logic                  err_q,      err_d;

  // Frame decode
  logic [WORD_SIZE-1:0]  head;
  logic [WORD_SIZE-1:0]  tail;
  logic                  valid_hdr;
  logic                  good;
  logic                  start_ok;
  logic [SEL_W-1:0]      tail_sel;
  logic [WORD_NUM-1:0]   tail_onehot;
  logic [3:0]            miss_inc;
  logic                  accept;

  assign head      = data_in[BUS_SIZE-1 -: WORD_SIZE];
  assign tail      = data_in[WORD_SIZE-1:0];
  assign valid_hdr = (head == {WORD_SIZE{1'b1}});
  assign good      = valid_hdr && (tail == expected_q);
  // A start frame restarts the sequence from WAIT or ERROR only; in ACTIVE a
  // tail of zero is simply a mismatch unless the sequence has wrapped to zero.
  assign start_ok  = valid_hdr && (tail == '0);

  // Divisor is a constant, so this folds into a small lookup on the tail.
  assign tail_sel    = SEL_W'(tail % WORD_SIZE'(WORD_NUM));
  assign tail_onehot = {{(WORD_NUM-1){1'b0}}, 1'b1} << tail_sel;
  assign miss_inc    = miss_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    miss_d     = miss_q;
    accept     = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT;
      end

      ST_WAIT, ST_ERROR: begin
        if (start_ok) begin
          accept     = 1'b1;
          state_d    = ST_ACTIVE;
          expected_d = WORD_SIZE'(1);
          miss_d     = '0;
        end
      end

      ST_ACTIVE: begin
        if (good) begin
          accept     = 1'b1;
          // Sequence number wraps naturally at 2^WORD_SIZE.
          expected_d = expected_q + WORD_SIZE'(1);
          miss_d     = '0;
        end else begin
          miss_d = miss_inc;
          if (miss_inc >= THRESH) begin
            state_d = ST_ERROR;
          end
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    rot_en_d  = accept;
    rot_sel_d = accept ? tail_sel    : '0;
    ctrl_d    = accept ? tail_onehot : '0;
    // Error flag follows the next state so it rises and falls in the same
    // output cycle as the frame that causes the transition.
    err_d     = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      expected_q <= '0;
      miss_q     <= '0;
      frame_q    <= '0;
      rot_en_q   <= 1'b0;
      rot_sel_q  <= '0;
      ctrl_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      miss_q     <= miss_d;
      frame_q    <= data_in;
      rot_en_q   <= rot_en_d;
      rot_sel_q  <= rot_sel_d;
      ctrl_q     <= ctrl_d;
      err_q      <= err_d;
    end
  end

  assign data_q      = frame_q;
  assign rot_en      = rot_en_q;
  assign rot_sel     = rot_sel_q;
  assign control_out = ctrl_q;
  assign error_out   = err_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_control_rotador.sv
// ---------------------------------------------------------------------------
// tb_control_rotador
//   Self-checking bench for control_rotador. A frame-level reference model
//   predicts every output after each clock; directed sequences cover start,
//   in-sequence, error entry/exit, sequence wrap and asynchronous reset,
//   followed by a randomized soak with occasional resets.
// ---------------------------------------------------------------------------
module tb_control_rotador;

  localparam int BUS_SIZE   = 60;
  localparam int WORD_SIZE  = 6;
  localparam int WORD_NUM   = 10;
  localparam int SEL_W      = 4;
  localparam int ERR_THRESH = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [BUS_SIZE-1:0] data_in = '0;
  logic [BUS_SIZE-1:0] data_q;
  logic                rot_en;
  logic [SEL_W-1:0]    rot_sel;
  logic [WORD_NUM-1:0] control_out;
  logic                error_out;
  logic [1:0]          state_out;

  control_rotador #(
    .BUS_SIZE  (BUS_SIZE),
    .WORD_SIZE (WORD_SIZE),
    .WORD_NUM  (WORD_NUM),
    .SEL_W     (SEL_W),
    .ERR_THRESH(ERR_THRESH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_q     (data_q),
    .rot_en     (rot_en),
    .rot_sel    (rot_sel),
    .control_out(control_out),
    .error_out  (error_out),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: 0=reset, 1=wait, 2=active, 3=error
  int                  m_state;
  int                  m_exp;
  int                  m_miss;
  logic [BUS_SIZE-1:0] e_data;
  logic                e_en;
  int                  e_sel;
  logic [WORD_NUM-1:0] e_ctrl;
  logic                e_err;
  int                  e_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS_SIZE-1:0] mk_frame(input logic [5:0] head, input logic [5:0] tail);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {head, r[47:0], tail};
  endfunction

  function automatic logic [5:0] bad_head();
    return 6'($urandom_range(0, 62));
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_miss = 0;
    e_data = '0; e_en = 1'b0; e_sel = 0; e_ctrl = '0; e_err = 1'b0; e_state = 0;
  endtask

  task automatic model_step(input logic [BUS_SIZE-1:0] frame);
    logic [5:0] head;
    logic [5:0] tail;
    bit         hdr;
    bit         acc;
    head = frame[59:54];
    tail = frame[5:0];
    hdr  = (head == 6'h3F);
    acc  = 0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1 || m_state == 3) begin
      if (hdr && tail == 0) begin
        acc = 1; m_state = 2; m_exp = 1; m_miss = 0;
      end
    end else begin
      if (hdr && int'(tail) == m_exp) begin
        acc = 1; m_exp = (m_exp + 1) % 64; m_miss = 0;
      end else begin
        m_miss++;
        if (m_miss >= ERR_THRESH) m_state = 3;
      end
    end
    e_data  = frame;
    e_en    = acc;
    e_sel   = acc ? int'(tail) % WORD_NUM : 0;
    e_ctrl  = '0;
    if (acc) e_ctrl[e_sel] = 1'b1;
    e_err   = (m_state == 3);
    e_state = m_state;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_q"},  data_q,      e_data);
    chk({tag, ".rot_en"},  rot_en,      e_en);
    chk({tag, ".rot_sel"}, rot_sel,     e_sel);
    chk({tag, ".ctrl"},    control_out, e_ctrl);
    chk({tag, ".err"},     error_out,   e_err);
    chk({tag, ".state"},   state_out,   e_state);
  endtask

  // Drive one frame (away from the edge), advance one clock, check outputs.
  task automatic cycle(input logic [BUS_SIZE-1:0] frame, input string tag);
    data_in = frame;
    if (!reset) model_reset();
    else        model_step(frame);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Assert reset between clock edges and check outputs clear immediately.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    logic [BUS_SIZE-1:0] f;
    int r;
    model_reset();

    // 1: held in reset with random frames
    for (int i = 0; i < 5; i++) begin
      f = {$urandom, $urandom};
      cycle(f, "rst_hold");
    end
    reset = 1'b1;
    cycle(mk_frame(6'h3F, 6'd0), "rst_rel");
    chk("rel_state", state_out, 2'b01);
    chk("rel_en", rot_en, 1'b0);

    // 2: in-sequence start
    for (int t = 0; t < 3; t++) begin
      cycle(mk_frame(6'h3F, 6'(t)), "seq");
      chk("seq_en", rot_en, 1'b1);
      chk("seq_sel", rot_sel, 4'(t));
    end
    chk("seq_ctrl2", control_out, 10'h004);
    chk("seq_state", state_out, 2'b10);

    // 3: one bad frame, then continue
    cycle(mk_frame(bad_head(), 6'd3), "miss1");
    chk("miss1_en", rot_en, 1'b0);
    cycle(mk_frame(6'h3F, 6'd3), "resume");
    chk("resume_sel", rot_sel, 4'd3);
    chk("resume_err", error_out, 1'b0);

    // 4: error entry and exit
    cycle(mk_frame(bad_head(), 6'($urandom)), "bad1");
    cycle(mk_frame(bad_head(), 6'($urandom)), "bad2");
    chk("err_set", error_out, 1'b1);
    chk("err_state", state_out, 2'b11);
    cycle(mk_frame(6'h3F, 6'd9), "err_stay");
    chk("err_stay_state", state_out, 2'b11);
    cycle(mk_frame(6'h3F, 6'd0), "err_exit");
    chk("err_exit_state", state_out, 2'b10);
    chk("err_exit_err", error_out, 1'b0);
    chk("err_exit_en", rot_en, 1'b1);

    // 5: run to tail 63 and wrap
    for (int t = 1; t < 64; t++) cycle(mk_frame(6'h3F, 6'(t)), "run");
    chk("wrap_sel", rot_sel, 4'd3);
    chk("wrap_ctrl", control_out, 10'h008);
    cycle(mk_frame(6'h3F, 6'd0), "wrap0");
    chk("wrap0_en", rot_en, 1'b1);
    // tail 0 while expecting 1 is a bad frame, not a resync
    cycle(mk_frame(6'h3F, 6'd0), "no_resync");
    chk("no_resync_en", rot_en, 1'b0);

    // 6: async reset mid-ACTIVE
    cycle(mk_frame(6'h3F, 6'd1), "pre_rst");
    async_reset("async");
    chk("async_state", state_out, 2'b00);
    cycle(mk_frame(6'h3F, 6'd0), "async_hold");
    reset = 1'b1;

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      f = mk_frame(6'h3F, 6'(m_exp));
      else if (r < 55) f = mk_frame(6'h3F, 6'd0);
      else if (r < 70) f = mk_frame(6'h3F, 6'($urandom));
      else             f = mk_frame(bad_head(), 6'($urandom));
      cycle(f, "rand");
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_async");
        cycle(mk_frame(6'h3F, 6'd0), "rand_hold");
        reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
